// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, busy scoreboard and sequential clear engine
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  output logic                ready_o,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic [NWR-1:0]      wen_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic                issue_en_i,
  input  logic [AW-1:0]       issue_rd_i
);
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  logic             state;
  logic [AW-1:0]    clr_idx;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             run;
  assign run     = state == ST_RUN;
  assign ready_o = run;
  // Ascending port loop: the last non-blocking write wins, so the highest port index has priority.
  // The issue set is applied after the write clears so a new producer supersedes a resolving one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      clr_idx <= AW'(1);
      busy    <= '0;
    end else if (!run) begin
      regs[clr_idx] <= '0;
      clr_idx       <= clr_idx + AW'(1);
      if (clr_idx == AW'(NREGS - 1)) state <= ST_RUN;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wen_i[j] && waddr_i[j*AW +: AW] != '0) begin
          regs[waddr_i[j*AW +: AW]] <= wdata_i[j*XLEN +: XLEN];
          busy[waddr_i[j*AW +: AW]] <= 1'b0;
        end
      end
      if (clear_i) begin
        state   <= ST_INIT;
        clr_idx <= AW'(1);
        busy    <= '0;
      end else if (issue_en_i && issue_rd_i != '0) begin
        busy[issue_rd_i] <= 1'b1;
      end
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            hit;
    logic [XLEN-1:0] fwd;
    assign ra = raddr_i[k*AW +: AW];
    always_comb begin
      hit = 1'b0;
      fwd = regs[ra];
      for (int j = 0; j < NWR; j++) begin
        if (wen_i[j] && waddr_i[j*AW +: AW] == ra) begin
          hit = 1'b1;
          fwd = wdata_i[j*XLEN +: XLEN];
        end
      end
    end
    assign rdata_o[k*XLEN +: XLEN] = (run && ra != '0) ? fwd : '0;
    assign rbusy_o[k]              = run && ra != '0 && busy[ra] && !hit;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, AW = 5, NRD = 2, NWR = 2;
  logic                clk = 0;
  logic                rst_n = 0;
  logic                clear_i = 0;
  logic                ready_o;
  logic [NRD*AW-1:0]   raddr_i = '0;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]      rbusy_o;
  logic [NWR-1:0]      wen_i = '0;
  logic [NWR*AW-1:0]   waddr_i = '0;
  logic [NWR*XLEN-1:0] wdata_i = '0;
  logic                issue_en_i = 0;
  logic [AW-1:0]       issue_rd_i = '0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .ready_o(ready_o),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .rbusy_o(rbusy_o),
    .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .issue_en_i(issue_en_i), .issue_rd_i(issue_rd_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [XLEN-1:0] mem [NREGS];
  bit mbusy [NREGS];
  int init_left = NREGS - 1;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    logic [XLEN-1:0] r;
    if (init_left != 0 || a == 0) return '0;
    r = mem[a];
    for (int j = 0; j < NWR; j++) if (wen_i[j] && waddr_i[j*AW +: AW] == a) r = wdata_i[j*XLEN +: XLEN];
    return r;
  endfunction

  function automatic logic exp_bz(input logic [AW-1:0] a);
    bit hit = 0;
    if (init_left != 0 || a == 0) return 1'b0;
    for (int j = 0; j < NWR; j++) if (wen_i[j] && waddr_i[j*AW +: AW] == a) hit = 1;
    return mbusy[a] && !hit;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      init_left = NREGS - 1;
      foreach (mbusy[i]) mbusy[i] = 0;
    end else if (init_left > 0) begin
      mem[NREGS - init_left] = '0;
      init_left--;
    end else begin
      for (int j = 0; j < NWR; j++) if (wen_i[j] && waddr_i[j*AW +: AW] != 0) begin
        mem[waddr_i[j*AW +: AW]] = wdata_i[j*XLEN +: XLEN];
        mbusy[waddr_i[j*AW +: AW]] = 0;
      end
      if (clear_i) begin
        init_left = NREGS - 1;
        foreach (mbusy[i]) mbusy[i] = 0;
      end else if (issue_en_i && issue_rd_i != 0) mbusy[issue_rd_i] = 1;
    end
  endtask

  task automatic cyc();
    #2;
    check("ready", XLEN'(ready_o), XLEN'(init_left == 0));
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("rdata%0d", k), rdata_o[k*XLEN +: XLEN], exp_rd(raddr_i[k*AW +: AW]));
      check($sformatf("rbusy%0d", k), XLEN'(rbusy_o[k]), XLEN'(exp_bz(raddr_i[k*AW +: AW])));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    clear_i = 0; wen_i = '0; waddr_i = '0; wdata_i = '0; issue_en_i = 0; issue_rd_i = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wen_i[p] = 1'b1; waddr_i[p*AW +: AW] = a; wdata_i[p*XLEN +: XLEN] = d;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 64) begin
      #1;
      if (ready_o === 1'b1) break;
      cyc();
      n++;
    end
  endtask

  int n;

  initial begin
    foreach (mem[i]) mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    wr(0, 5'd3, 32'hDEAD);
    issue_en_i = 1; issue_rd_i = 5'd3; clear_i = 1;
    raddr_i = {5'd3, 5'd5};
    wait_ready(n);
    check("init_len", n, 31);
    idle();
    cyc();
    #1;
    check("x5_zero", rdata_o[0 +: XLEN], '0);
    check("x3_zero", rdata_o[XLEN +: XLEN], '0);
    check("x3_nbusy", XLEN'(rbusy_o[1]), '0);
    cyc();

    wr(0, 5'd7, 32'h12345678); raddr_i = {5'd0, 5'd7};
    #1 check("byp_x7", rdata_o[0 +: XLEN], 32'h12345678);
    cyc();
    idle();
    #1 check("st_x7", rdata_o[0 +: XLEN], 32'h12345678);
    cyc();

    wr(0, 5'd9, 32'hAAAA_AAAA); wr(1, 5'd9, 32'h5555_5555); raddr_i = {5'd9, 5'd9};
    #1 check("byp_x9", rdata_o[0 +: XLEN], 32'h5555_5555);
    cyc();
    idle();
    #1 check("st_x9", rdata_o[XLEN +: XLEN], 32'h5555_5555);
    cyc();

    wr(0, 5'd0, 32'hFFFF_FFFF); issue_en_i = 1; issue_rd_i = 5'd0; raddr_i = {5'd0, 5'd0};
    #1 check("x0_byp", rdata_o[0 +: XLEN], '0);
    cyc();
    idle();
    #1 check("x0_rd", rdata_o[0 +: XLEN], '0);
    check("x0_nbusy", XLEN'(rbusy_o[0]), '0);
    cyc();

    issue_en_i = 1; issue_rd_i = 5'd4; raddr_i = {5'd0, 5'd4};
    #1 check("iss_same_cyc", XLEN'(rbusy_o[0]), '0);
    cyc();
    idle();
    #1 check("x4_busy", XLEN'(rbusy_o[0]), 1);
    cyc();
    wr(1, 5'd4, 32'hCAFE_0004);
    #1 check("x4_resolve", XLEN'(rbusy_o[0]), '0);
    check("x4_fwd", rdata_o[0 +: XLEN], 32'hCAFE_0004);
    cyc();
    idle();
    #1 check("x4_free", XLEN'(rbusy_o[0]), '0);
    issue_en_i = 1; issue_rd_i = 5'd4; wr(0, 5'd4, 32'h0000_0444);
    cyc();
    idle();
    #1 check("x4_set_wins", XLEN'(rbusy_o[0]), 1);
    cyc();

    for (int c = 0; c < 300; c++) begin
      raddr_i = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      wen_i = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        waddr_i[j*AW +: AW] = ($urandom % 2) ? AW'($urandom) : AW'($urandom_range(0, 7));
        wdata_i[j*XLEN +: XLEN] = $urandom;
      end
      issue_en_i = $urandom % 2;
      issue_rd_i = AW'($urandom_range(0, 7));
      clear_i = ($urandom % 64) == 0;
      if (ready_o !== 1'b1) clear_i = 0;
      cyc();
    end
    idle();
    wait_ready(n);

    for (int a = 1; a < NREGS; a += 2) begin
      wr(0, AW'(a), 32'h1000_0000 + a);
      if (a + 1 < NREGS) wr(1, AW'(a + 1), 32'h2000_0000 + a);
      issue_en_i = 1; issue_rd_i = AW'(a);
      cyc();
      idle();
    end
    raddr_i = {5'd31, 5'd30};
    #1 check("pre_clr_x31", rdata_o[XLEN +: XLEN], 32'h1000_001F);
    clear_i = 1;
    cyc();
    idle();
    wait_ready(n);
    check("clr_len", n, 31);
    for (int a = 0; a < NREGS; a += 2) begin
      raddr_i = {AW'(a + 1), AW'(a)};
      #1 check("clr_rd0", rdata_o[0 +: XLEN], '0);
      check("clr_rd1", rdata_o[XLEN +: XLEN], '0);
      check("clr_bz", XLEN'(rbusy_o), '0);
      cyc();
    end

    clear_i = 1;
    cyc();
    idle();
    repeat (10) cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    wait_ready(n);
    check("rst_restart_len", n, 31);
    raddr_i = {5'd9, 5'd7};
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V core. Successor to the single-write, two-read register file.
- Adds: configurable width, depth and read/write port counts; priority-resolved multi-write; write-to-read bypass on every read port; per-register busy scoreboard for hazard detection in ID.
- Adds a sequential clear engine that zeroes entries one per cycle after reset or on request, gated by ready_o.
- Sits between ID (read/issue) and EX/WB (write-back).

Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of 2, ≥4); entry 0 hardwired to zero
- AW, 5, address width, equal to log2(NREGS)
- NRD, 2, number of read ports (≥1)
- NWR, 2, number of write ports (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- clear_i  in  1  request full register clear, honoured only in RUN
- ready_o  out  1  1 when in RUN; reads, writes and issues are valid only then
- raddr_i  in  NRD*AW  read addresses; port k at bits [k*AW +: AW]
- rdata_o  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
- rbusy_o  out  NRD  port k's register has a pending, unresolved producer
- wen_i  in  NWR  write enables
- waddr_i  in  NWR*AW  write addresses
- wdata_i  in  NWR*XLEN  write data
- issue_en_i  in  1  ID issues an instruction that writes a register
- issue_rd_i  in  AW  destination of the issued instruction

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
  - While rst_n=0 at a posedge: state←INIT, clr_idx←1, busy[]←0.
  - Outputs during and after reset: ready_o=0, rdata_o=0, rbusy_o=0.
- FSM INIT:
  - Each cycle writes 0 to entry clr_idx and increments clr_idx.
  - When clr_idx=NREGS-1 is cleared, go to RUN next cycle. INIT lasts exactly NREGS-1 cycles; ready_o=1 on the first RUN cycle.
  - In INIT: wen_i, issue_en_i and clear_i are ignored; all rdata_o=0 and rbusy_o=0.
- FSM RUN:
  - clear_i=1 → INIT next cycle; clr_idx←1, busy[]←0.
  - Writes on that same cycle still commit, but are then overwritten by the clear.
- Entry 0:
  - Never written and never busy.
  - Reads of address 0 return 0, with rbusy=0.
- Write: at a posedge in RUN, each port j with wen_i[j]=1 and waddr≠0 writes wdata_j.
  - Same address on multiple ports: highest port index wins.
- Read (combinational, zero latency), in RUN, per port k:
  - addr=0 → 0.
  - Else, if any enabled write port matches addr, the highest-index matching port's wdata (bypass).
  - Else the stored value.
- Scoreboard busy[NREGS]:
  - Set: issue_en_i=1 and issue_rd_i≠0 sets busy[issue_rd_i] at the next edge.
  - Clear: an enabled write to address a≠0 clears busy[a].
  - Set and clear of the same register in one cycle: set wins, because the new producer supersedes.
  - Issue to a non-busy register, or a write to a non-busy register: legal, no error.
- rbusy_o[k] = busy[raddr_k] AND NOT (any enabled write port matches raddr_k this cycle). A resolving write is forwarded, so no stall.
- The issue in the current cycle does not affect rbusy_o until the next cycle.
- Reset asserted mid-INIT or mid-RUN: restarts INIT from clr_idx=1. Contents become zero only after INIT completes, and reads are masked to zero meanwhile.

Test Plan:
- Reset release, NREGS=32:
  - ready_o=0 for 31 cycles, 1 on cycle 32.
  - Read x5 → 0.
  - wen asserted during INIT (x3←0xDEAD) has no effect; x3 reads 0 afterwards.
- Write x7←0x12345678 on port 0 with raddr0=x7 the same cycle:
  - rdata0 = 0x12345678 combinationally (bypass).
  - Next cycle, with no write, still 0x12345678.
- Both write ports target x9 (port0 0xAAAA_AAAA, port1 0x5555_5555):
  - Read bypass and stored value are both 0x5555_5555.
- Write to x0 with 0xFFFF_FFFF:
  - Reads return 0, rbusy=0.
  - issue_rd=0 never sets busy.
- Scoreboard:
  - Issue x4 → next cycle rbusy=1 for raddr=x4.
  - Write x4 → rbusy=0 that same cycle, with data forwarded.
  - Issue x4 and write x4 in the same cycle → busy stays 1.
- clear_i in RUN after writing x1..x31 with nonzero values:
  - ready_o drops for 31 cycles and busy is cleared.
  - All registers read 0 afterwards.
  - Asserting rst_n=0 mid-clear restarts the 31-cycle count.
